// File: rtl/display_pkg.sv
// display_pkg
// Shared constants and FSM state type for the digit display / scroll logic.
//   ROW_PITCH      : pixel height of one display row (scroll distance per shift)
//   DIGITS_PER_ROW : digits shown in one row
//   NUM_ROWS       : rows visible on screen
//   BLANK_DIGIT    : code rendered as an empty digit cell
package display_pkg;

    localparam int         ROW_PITCH      = 150;
    localparam int         DIGITS_PER_ROW = 6;
    localparam int         NUM_ROWS       = 4;
    localparam logic [3:0] BLANK_DIGIT    = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        SHIFT  = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/digit_scroll_ctrl.sv
// digit_scroll_ctrl
// Digit entry and row-scroll controller for a four-row digit display.
// Digits are typed into row 1; a commit latches the verdict and scrolls the
// screen up by one row, pulling a new row in at the bottom.
//
// Build option: define SCROLL_ANIM_EN for a per-frame animated scroll.
// Without it, a commit shifts the rows straight away and o_displacement
// stays 0 (STEP and i_frame_tick are then unused).
//
// state  | meaning
// IDLE   | accepting digit entry, backspace and commit
// SCROLL | animating upward scroll, one STEP per frame tick
// SHIFT  | one-cycle row move, then back to IDLE
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_frame_tick          one-cycle pulse per video frame
//   i_digit_valid/i_digit digit strobe and value (0..9)
//   i_backspace           erase last entered digit
//   i_commit/i_correct    answer commit strobe and its verdict
//   i_next_row            six digits for the new bottom row, MSB nibble leftmost
//   o_ready               high while entry/commit are accepted
//   o_digit_showed        24 digits, index k at bits [95-4k -: 4]
//   o_correctness         bit0 row 0 verdict, bit1 verdict of the row in flight
//   o_displacement        vertical scroll offset in pixels
module digit_scroll_ctrl
    import display_pkg::*;
#(
    parameter int STEP = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame_tick,
    input  logic        i_digit_valid,
    input  logic [3:0]  i_digit,
    input  logic        i_backspace,
    input  logic        i_commit,
    input  logic        i_correct,
    input  logic [23:0] i_next_row,
    output logic        o_ready,
    output logic [95:0] o_digit_showed,
    output logic [1:0]  o_correctness,
    output logic [10:0] o_displacement
);

    localparam int         ROW_BITS   = DIGITS_PER_ROW * 4;
    localparam int         ALL_BITS   = NUM_ROWS * ROW_BITS;
    // Entry stops one short of the row width: the last cell of the entry
    // row is never written by typing.
    localparam logic [2:0] CURSOR_MAX = 3'(DIGITS_PER_ROW - 1);

    scroll_state_t       state, state_nxt;
    logic [2:0]          cursor, cursor_nxt;
    logic [ALL_BITS-1:0] digits, digits_nxt;
    logic [1:0]          corr, corr_nxt;
    logic [10:0]         disp, disp_nxt;
    logic                ready_q;

    // MSB position of entry-row cell 'pos' (global digit index 6+pos).
    function automatic int entry_msb(input logic [2:0] pos);
        return ALL_BITS - 1 - 4 * (DIGITS_PER_ROW + int'(pos));
    endfunction

`ifdef SCROLL_ANIM_EN
    localparam logic [11:0] STEP_W = 12'(STEP);
    logic [11:0] disp_sum;
    assign disp_sum = {1'b0, disp} + STEP_W;
`else
    logic unused_cfg;
    assign unused_cfg = ^{i_frame_tick, 32'(STEP), 32'(ROW_PITCH)};
`endif

    always_comb begin
        state_nxt  = state;
        cursor_nxt = cursor;
        digits_nxt = digits;
        corr_nxt   = corr;
        disp_nxt   = disp;
        case (state)
            IDLE: begin
                // A digit always takes priority over a same-cycle backspace,
                // even when the digit itself is dropped at a full row.
                if (i_digit_valid) begin
                    if (cursor < CURSOR_MAX) begin
                        digits_nxt[entry_msb(cursor) -: 4] = i_digit;
                        cursor_nxt = cursor + 3'd1;
                    end
                end else if (i_backspace && (cursor != 3'd0)) begin
                    digits_nxt[entry_msb(cursor - 3'd1) -: 4] = BLANK_DIGIT;
                    cursor_nxt = cursor - 3'd1;
                end
                if (i_commit) begin
                    corr_nxt[1] = i_correct;
`ifdef SCROLL_ANIM_EN
                    disp_nxt  = STEP_W[10:0];
                    state_nxt = SCROLL;
`else
                    state_nxt = SHIFT;
`endif
                end
            end
            SCROLL: begin
`ifdef SCROLL_ANIM_EN
                if (i_frame_tick) begin
                    // Shift instead of stepping onto or past a full row.
                    if (disp_sum >= 12'(ROW_PITCH)) begin
                        state_nxt = SHIFT;
                    end else begin
                        disp_nxt = disp_sum[10:0];
                    end
                end
`else
                state_nxt = IDLE;
`endif
            end
            SHIFT: begin
                digits_nxt = {digits[ALL_BITS-ROW_BITS-1:0], i_next_row};
                corr_nxt   = {1'b0, corr[1]};
                disp_nxt   = '0;
                cursor_nxt = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cursor  <= '0;
            digits  <= {(NUM_ROWS * DIGITS_PER_ROW){BLANK_DIGIT}};
            corr    <= '0;
            disp    <= '0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            cursor  <= cursor_nxt;
            digits  <= digits_nxt;
            corr    <= corr_nxt;
            disp    <= disp_nxt;
            ready_q <= (state_nxt == IDLE);
        end
    end

    assign o_ready        = ready_q;
    assign o_digit_showed = digits;
    assign o_correctness  = corr;
    assign o_displacement = disp;

endmodule

// File: tb/tb_digit_scroll_ctrl.sv
module tb_digit_scroll_ctrl;

    localparam int STEP_TB = 10;

    logic        i_clk;
    logic        i_rst;
    logic        i_frame_tick;
    logic        i_digit_valid;
    logic [3:0]  i_digit;
    logic        i_backspace;
    logic        i_commit;
    logic        i_correct;
    logic [23:0] i_next_row;
    logic        o_ready;
    logic [95:0] o_digit_showed;
    logic [1:0]  o_correctness;
    logic [10:0] o_displacement;

    digit_scroll_ctrl #(.STEP(STEP_TB)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_frame_tick   (i_frame_tick),
        .i_digit_valid  (i_digit_valid),
        .i_digit        (i_digit),
        .i_backspace    (i_backspace),
        .i_commit       (i_commit),
        .i_correct      (i_correct),
        .i_next_row     (i_next_row),
        .o_ready        (o_ready),
        .o_digit_showed (o_digit_showed),
        .o_correctness  (o_correctness),
        .o_displacement (o_displacement)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [95:0] dig;
        logic [1:0]  corr;
        logic [10:0] disp;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: screen as an array of 24 digit values plus a phase.
    // phase 0 = typing, 1 = scrolling, 2 = row move pending
    int m_dig[24];
    int m_cur;
    int m_phase;
    int m_c0, m_c1;
    int m_disp;

    task automatic model_reset();
        for (int k = 0; k < 24; k++) m_dig[k] = 15;
        m_cur = 0; m_phase = 0; m_c0 = 0; m_c1 = 0; m_disp = 0;
    endtask

    task automatic model_step(input bit rst, input bit tick, input bit dv, input int d,
                              input bit bs, input bit cm, input bit cr, input logic [23:0] nr);
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (dv) begin
                if (m_cur < 5) begin
                    m_dig[6 + m_cur] = d;
                    m_cur = m_cur + 1;
                end
            end else if (bs && m_cur > 0) begin
                m_cur = m_cur - 1;
                m_dig[6 + m_cur] = 15;
            end
            if (cm) begin
                m_c1 = cr;
`ifdef SCROLL_ANIM_EN
                m_disp  = STEP_TB;
                m_phase = 1;
`else
                m_phase = 2;
`endif
            end
        end else if (m_phase == 1) begin
            if (tick) begin
                if (m_disp + STEP_TB >= 150) m_phase = 2;
                else m_disp = m_disp + STEP_TB;
            end
        end else begin
            for (int k = 0; k < 18; k++) m_dig[k] = m_dig[k + 6];
            for (int j = 0; j < 6; j++) m_dig[18 + j] = int'(nr[23 - 4*j -: 4]);
            m_c0 = m_c1; m_c1 = 0; m_disp = 0; m_cur = 0; m_phase = 0;
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        e.dig = '0;
        for (int k = 0; k < 24; k++) e.dig[95 - 4*k -: 4] = 4'(m_dig[k]);
        e.corr = {1'(m_c1), 1'(m_c0)};
        e.disp = 11'(m_disp);
        e.rdy  = (m_phase == 0);
        return e;
    endfunction

    task automatic cyc(input bit rst, input bit tick, input bit dv, input int d,
                       input bit bs, input bit cm, input bit cr, input logic [23:0] nr);
        i_rst = rst; i_frame_tick = tick; i_digit_valid = dv; i_digit = 4'(d);
        i_backspace = bs; i_commit = cm; i_correct = cr; i_next_row = nr;
        model_step(rst, tick, dv, d, bs, cm, cr, nr);
        exp_q.push_back(model_view());
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(0, 0, 0, 0, 0, 0, 0, 24'h0);
    endtask

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: one expected snapshot per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        @(posedge i_clk);
        forever begin
            @(negedge i_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("digits",       96'(o_digit_showed), 96'(e.dig));
                chk("correctness",  96'(o_correctness),  96'(e.corr));
                chk("displacement", 96'(o_displacement), 96'(e.disp));
                chk("ready",        96'(o_ready),        96'(e.rdy));
                chk("disp_below_pitch", 96'(o_displacement < 11'd150), 96'(1));
            end
        end
    end

    initial begin
        int n;
        model_reset();
        // reset and entry / backspace
        cyc(1, 0, 0, 0, 0, 0, 0, 24'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 24'h0);
        idle_cyc();
        cyc(0, 0, 0, 0, 1, 0, 0, 24'h0);          // backspace at cursor 0
        cyc(0, 0, 1, 1, 0, 0, 0, 24'h0);
        cyc(0, 0, 1, 2, 0, 0, 0, 24'h0);
        cyc(0, 0, 1, 3, 0, 0, 0, 24'h0);
        cyc(0, 0, 0, 0, 1, 0, 0, 24'h0);
        cyc(0, 0, 1, 7, 0, 0, 0, 24'h0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, (4 + i) % 10, 0, 0, 0, 24'h0);
        cyc(0, 0, 1, 9, 1, 0, 0, 24'h0);          // digit beats backspace at full row
        cyc(0, 0, 0, 0, 1, 0, 0, 24'h0);
        cyc(0, 0, 1, 8, 1, 0, 0, 24'h0);          // digit beats backspace
        // commit correct, scroll with ignored inputs, ticks to the shift
        cyc(0, 0, 0, 0, 0, 1, 1, 24'h123456);
        cyc(0, 0, 1, 5, 1, 1, 0, 24'h123456);
        for (int i = 0; i < 16; i++) cyc(0, 1, (i % 3) == 0, 2, (i % 2) == 0, (i % 4) == 1, 0, 24'h987654);
        idle_cyc();
        // reset in the middle of a scroll
        cyc(0, 0, 1, 4, 0, 0, 0, 24'h0);
        cyc(0, 0, 1, 6, 0, 1, 1, 24'hABCDEF);     // digit written before commit
        n = 0;
        while (m_disp != 80 && n < 20) begin
            cyc(0, 1, 0, 0, 0, 0, 0, 24'h111111);
            n++;
        end
        cyc(1, 1, 0, 0, 0, 0, 0, 24'h222222);
        idle_cyc();
        // commit incorrect, then quiet cycles
        cyc(0, 0, 1, 3, 0, 0, 0, 24'h0);
        cyc(0, 0, 0, 0, 0, 1, 0, 24'h456789);
        for (int i = 0; i < 18; i++) cyc(0, 1, 0, 0, 0, 0, 0, 24'h456789);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(99) < 1,
                $urandom_range(99) < 40,
                $urandom_range(99) < 40,
                int'($urandom_range(9)),
                $urandom_range(99) < 20,
                $urandom_range(99) < 6,
                $urandom_range(1) == 1,
                24'($urandom()));
        end
        idle_cyc();
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge i_clk);
            n++;
        end
        @(negedge i_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
